// File: rtl/rf_write_port_arbiter_if.sv
// Bundle between writeback/LLU/decode and the register-file write port arbiter.
interface rf_write_port_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        llu_valid;
  logic [4:0]  llu_addr;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        hazard;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  modport master (
    output wb_we, wb_addr, wb_data, llu_valid, llu_addr, llu_data,
           issue_valid, issue_addr, rs_addr, rt_addr,
    input  llu_ready, hazard, pipe_stall, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, llu_valid, llu_addr, llu_data,
           issue_valid, issue_addr, rs_addr, rt_addr,
    output llu_ready, hazard, pipe_stall, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/rf_write_port_arbiter.sv
// Register-file write port arbiter: writeback stage vs long-latency unit.
// Tracks pending LLU destinations in a 32-bit scoreboard and flags RAW/WAW
// hazards to decode. Optional feature macro RF_ARB_STARVE_GUARD_EN adds a
// starvation counter that forces a one-cycle LLU grant while stalling the
// pipeline; without it WB has strict priority and pipe_stall is tied low.
module rf_write_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic                   clk,
  input logic                   rst,
  rf_write_port_arbiter_if.slave bus
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_FORCE = 1'b1;

  logic        wb_req;
  logic        grant_wb;
  logic        grant_llu;
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic        rf_we_q;
  logic [4:0]  rf_addr_q;
  logic [31:0] rf_data_q;

  // Register 0 is never a real destination, so a write to it is no request.
  assign wb_req = bus.wb_we & (bus.wb_addr != 5'd0);

`ifdef RF_ARB_STARVE_GUARD_EN
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Grant selection: FORCE serves only the LLU, ARB prefers WB.
  always_comb begin
    grant_wb  = 1'b0;
    grant_llu = 1'b0;
    if (!rst) begin
      if (state == ST_FORCE) grant_llu = bus.llu_valid;
      else if (wb_req)       grant_wb  = 1'b1;
      else                   grant_llu = bus.llu_valid;
    end
  end

  // Count consecutive denied LLU cycles; hitting the limit schedules FORCE.
  always_comb begin
    state_nxt = ST_ARB;
    cnt_nxt   = '0;
    if (state == ST_ARB && bus.llu_valid && !grant_llu) begin
      if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) state_nxt = ST_FORCE;
      else                                        cnt_nxt   = starve_cnt + 1'b1;
    end
  end

  // FSM and starvation counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARB;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  assign bus.pipe_stall = !rst && (state == ST_FORCE);
`else
  // Strict WB priority; the LLU only gets idle write-port cycles.
  always_comb begin
    grant_wb  = !rst & wb_req;
    grant_llu = !rst & !wb_req & bus.llu_valid;
  end

  assign bus.pipe_stall = 1'b0;
`endif

  assign bus.llu_ready = grant_llu;

  // Scoreboard next value: clear on LLU grant, then set on issue so set wins.
  always_comb begin
    busy_nxt = busy;
    if (grant_llu) busy_nxt[bus.llu_addr] = 1'b0;
    if (bus.issue_valid && bus.issue_addr != 5'd0) busy_nxt[bus.issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Hazard looks at registered busy bits only, so a write granted this
  // cycle still stalls decode until the following cycle.
  assign bus.hazard = !rst & (busy[bus.rs_addr] | busy[bus.rt_addr] |
                              (bus.issue_valid & busy[bus.issue_addr]));

  // Write port register: one-cycle latency, address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= 32'd0;
    end else if (grant_wb) begin
      rf_we_q   <= 1'b1;
      rf_addr_q <= bus.wb_addr;
      rf_data_q <= bus.wb_data;
    end else if (grant_llu && bus.llu_addr != 5'd0) begin
      rf_we_q   <= 1'b1;
      rf_addr_q <= bus.llu_addr;
      rf_data_q <= bus.llu_data;
    end else begin
      rf_we_q   <= 1'b0;
    end
  end

  assign bus.rf_we   = rf_we_q;
  assign bus.rf_addr = rf_addr_q;
  assign bus.rf_data = rf_data_q;

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Directed bench for rf_write_port_arbiter with a cycle-level reference model.
// Honors RF_ARB_STARVE_GUARD_EN the same way the design does.
module tb_rf_write_port_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rf_write_port_arbiter_if bus();

  rf_write_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ok = 0;
  bit          m_busy [32];
  int          m_denied;      // length of the current run of denied LLU cycles
  bit          m_force;       // this cycle is the forced LLU slot
  logic        m_rf_we;
  logic [4:0]  m_rf_addr;
  logic [31:0] m_rf_data;

  always @(negedge clk) begin
    bit g_wb, g_llu, haz, stall;
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_denied = 0; m_force = 0;
      m_rf_we = 0; m_rf_addr = 0; m_rf_data = 0;
      m_ok = 1;
    end else if (m_ok) begin
      stall = m_force;
      if (m_force) begin
        g_wb  = 0;
        g_llu = bus.llu_valid;
      end else begin
        g_wb  = bus.wb_we && bus.wb_addr != 0;
        g_llu = !g_wb && bus.llu_valid;
      end
      haz = m_busy[bus.rs_addr] || m_busy[bus.rt_addr] ||
            (bus.issue_valid && m_busy[bus.issue_addr]);

      chk("rf_we",      bus.rf_we,      m_rf_we);
      chk("rf_addr",    bus.rf_addr,    m_rf_addr);
      chk("rf_data",    bus.rf_data,    m_rf_data);
      chk("llu_ready",  bus.llu_ready,  g_llu);
      chk("pipe_stall", bus.pipe_stall, stall);
      chk("hazard",     bus.hazard,     haz);

      // write port result for next cycle
      if (g_wb) begin
        m_rf_we = 1; m_rf_addr = bus.wb_addr; m_rf_data = bus.wb_data;
      end else if (g_llu && bus.llu_addr != 0) begin
        m_rf_we = 1; m_rf_addr = bus.llu_addr; m_rf_data = bus.llu_data;
      end else begin
        m_rf_we = 0;
      end
      // scoreboard: clear then set, so set wins on a shared index
      if (g_llu) m_busy[bus.llu_addr] = 0;
      if (bus.issue_valid && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1;
`ifdef RF_ARB_STARVE_GUARD_EN
      if (m_force) begin
        m_force = 0; m_denied = 0;
      end else if (bus.llu_valid && !g_llu) begin
        m_denied++;
        if (m_denied == STARVE_LIMIT) begin
          m_denied = 0; m_force = 1;
        end
      end else begin
        m_denied = 0;
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.llu_valid = 0; bus.llu_addr = 0; bus.llu_data = 0;
    bus.issue_valid = 0; bus.issue_addr = 0;
    bus.rs_addr = 0; bus.rt_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we = 1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic llu(input logic [4:0] a, input logic [31:0] d);
    bus.llu_valid = 1; bus.llu_addr = a; bus.llu_data = d;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("reset rf_we", bus.rf_we, 0);
    chk("reset rf_addr", bus.rf_addr, 0);
    chk("reset rf_data", bus.rf_data, 0);
    chk("reset stall", bus.pipe_stall, 0);

    // plain WB write
    tick(); wb(5, 32'hDEADBEEF);
    @(negedge clk) chk("wb llu_ready", bus.llu_ready, 0);
    tick(); idle();
    @(negedge clk);
    chk("wb rf_we", bus.rf_we, 1);
    chk("wb rf_addr", bus.rf_addr, 5);
    chk("wb rf_data", bus.rf_data, 32'hDEADBEEF);

    // LLU issue, RAW hazard, return, hazard clears the cycle after grant
    tick(); bus.issue_valid = 1; bus.issue_addr = 9;
    tick(); idle(); bus.rs_addr = 9;
    @(negedge clk) chk("raw hazard", bus.hazard, 1);
    tick(); bus.rs_addr = 9; llu(9, 32'h1234);
    @(negedge clk);
    chk("llu ready", bus.llu_ready, 1);
    chk("hazard in grant cycle", bus.hazard, 1);
    tick(); idle(); bus.rs_addr = 9;
    @(negedge clk);
    chk("llu rf_addr", bus.rf_addr, 9);
    chk("llu rf_data", bus.rf_data, 32'h1234);
    chk("hazard after grant", bus.hazard, 0);

    // continuous WB traffic with a waiting LLU result
    tick(); wb(6, 32'h66); llu(7, 32'h77);
`ifdef RF_ARB_STARVE_GUARD_EN
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      @(negedge clk) chk("starve denied", bus.llu_ready, 0);
      tick();
    end
    @(negedge clk);
    chk("force stall", bus.pipe_stall, 1);
    chk("force ready", bus.llu_ready, 1);
    tick(); bus.llu_valid = 0;
    @(negedge clk);
    chk("force rf_addr", bus.rf_addr, 7);
    chk("force no stall", bus.pipe_stall, 0);
    tick(); idle();
    @(negedge clk);
    chk("held wb rf_addr", bus.rf_addr, 6);
    chk("held wb rf_data", bus.rf_data, 32'h66);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("strict denied", bus.llu_ready, 0);
      chk("strict no stall", bus.pipe_stall, 0);
      tick();
    end
    idle();
`endif

    // issue and LLU grant of the same register in one cycle; WB to r0
    tick(); bus.issue_valid = 1; bus.issue_addr = 3; llu(3, 32'h33); wb(0, 32'hAA);
    @(negedge clk) chk("r0 wb not request", bus.llu_ready, 1);
    tick(); idle(); bus.rs_addr = 3;
    @(negedge clk);
    chk("set wins hazard", bus.hazard, 1);
    chk("same cycle rf_addr", bus.rf_addr, 3);
    tick(); idle(); wb(0, 32'hAA); bus.issue_valid = 1; bus.issue_addr = 3;
    @(negedge clk) chk("issue waw hazard", bus.hazard, 1);
    tick(); idle(); llu(0, 32'hBB);
    @(negedge clk);
    chk("r0 wb rf_we", bus.rf_we, 0);
    chk("llu r0 ready", bus.llu_ready, 1);
    tick(); idle(); llu(3, 32'h3333); bus.rt_addr = 3;
    @(negedge clk) chk("llu r0 rf_we", bus.rf_we, 0);
    tick(); idle(); bus.rt_addr = 3;
    @(negedge clk) chk("rt clear", bus.hazard, 0);

    // reset while a forced grant (or WB write) is pending
    tick(); bus.issue_valid = 1; bus.issue_addr = 12;
    tick(); idle(); wb(6, 32'h6060); llu(7, 32'h7070);
`ifdef RF_ARB_STARVE_GUARD_EN
    for (int i = 0; i < STARVE_LIMIT; i++) tick();
    @(negedge clk) chk("pre-reset force", bus.pipe_stall, 1);
`endif
    rst = 1;
    tick(); rst = 0; idle(); bus.rs_addr = 12;
    @(negedge clk);
    chk("post-reset rf_we", bus.rf_we, 0);
    chk("post-reset stall", bus.pipe_stall, 0);
    chk("post-reset hazard", bus.hazard, 0);

    // mixed traffic after reset
    tick(); wb(1, 32'h11); llu(2, 32'h22);
    tick(); idle(); llu(2, 32'h22);
    tick(); idle();
    @(negedge clk) chk("mixed rf_addr", bus.rf_addr, 2);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected end before %0t", $time);
    $fatal(1);
  end
endmodule
